// File: rtl/jk_excitation_counter.sv
// Modulo-MOD up/down counter built from JK flip-flops: the next state D is
// computed per bit, encoded to J/K excitation, then applied by a JK update.
module jk_excitation_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             tc,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  // Wrap is at MOD, not 2**WIDTH; out-of-range states recover to the wrap target.
  function automatic logic [WIDTH-1:0] count_up(input logic [WIDTH-1:0] v);
    if (v >= LAST) count_up = '0;
    else           count_up = v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] count_dn(input logic [WIDTH-1:0] v);
    if (v == '0 || v > LAST) count_dn = LAST;
    else                     count_dn = v - 1'b1;
  endfunction

  function automatic logic jk_bit(input logic qi, input logic ji, input logic ki);
    case ({ji, ki})
      2'b00:   jk_bit = qi;
      2'b01:   jk_bit = 1'b0;
      2'b10:   jk_bit = 1'b1;
      default: jk_bit = ~qi;
    endcase
  endfunction

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q_nxt;
  logic             load_rej;

  always_comb begin
    d        = q;
    load_rej = 1'b0;
    if (load) begin
      if (load_val <= LAST) d = load_val;
      else                  load_rej = 1'b1;
    end else if (en) begin
      d = up_dn ? count_up(q) : count_dn(q);
    end
  end

  assign j_out = ~q & d;
  assign k_out = q & ~d;
  assign qbar  = ~q;
  assign tc    = en & ~load & (up_dn ? (q == LAST) : (q == '0));

  always_comb begin
    q_nxt = q;
    for (int i = 0; i < WIDTH; i++) begin
      q_nxt[i] = jk_bit(q[i], j_out[i], k_out[i]);
    end
  end

  // State register: JK-updated state and the rejected-load pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      load_err <= 1'b0;
    end else begin
      q        <= q_nxt;
      load_err <= load_rej;
    end
  end

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Directed and randomized checks of jk_excitation_counter against a behavioural model.
module tb_jk_excitation_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             clk = 1'b0;
  logic             reset, en, up_dn, load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q, qbar, j_out, k_out;
  logic             tc, load_err;

  int passes = 0;
  int total  = 0;

  jk_excitation_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q), .qbar(qbar), .j_out(j_out), .k_out(k_out),
    .tc(tc), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model state and helpers
  int mq, merr;

  function automatic int model_d(input int cq, input bit ld, input int lv, input bit e, input bit up);
    if (ld) return (lv < MOD) ? lv : cq;
    if (!e) return cq;
    if (up) return (cq >= MOD - 1) ? 0 : cq + 1;
    return (cq == 0 || cq >= MOD) ? MOD - 1 : cq - 1;
  endfunction

  initial begin
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;

    // 1. reset state
    tick(); tick();
    chk("rst_q", 32'(q), 32'(0));
    chk("rst_qbar", 32'(qbar), 32'hF);
    chk("rst_j", 32'(j_out), 32'(0));
    chk("rst_k", 32'(k_out), 32'(0));
    chk("rst_err", 32'(load_err), 32'(0));
    chk("rst_tc", 32'(tc), 32'(0));

    // 2. count up 12 clocks through the wrap
    reset = 1'b0; en = 1'b1; up_dn = 1'b1;
    mq = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("up_tc", 32'(tc), 32'(mq == 9));
      if (mq == 9) begin
        chk("up_wrap_k", 32'(k_out), 32'b1001);
        chk("up_wrap_j", 32'(j_out), 32'(0));
      end
      tick();
      mq = (mq == 9) ? 0 : mq + 1;
      chk("up_q", 32'(q), 32'(mq));
    end

    // 3. count down from 0 wraps to 9
    load = 1'b1; load_val = 4'd0; en = 1'b0;
    tick();
    chk("ld0_q", 32'(q), 32'(0));
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    #1;
    chk("dn_j", 32'(j_out), 32'b1001);
    chk("dn_k", 32'(k_out), 32'(0));
    chk("dn_tc", 32'(tc), 32'(1));
    tick();
    chk("dn_q", 32'(q), 32'(9));

    // 4. load beats en; out-of-range load rejected
    load = 1'b1; load_val = 4'd7; en = 1'b1; up_dn = 1'b1;
    #1;
    chk("ld_tc_masked", 32'(tc), 32'(0));
    tick();
    chk("ld7_q", 32'(q), 32'(7));
    chk("ld7_err", 32'(load_err), 32'(0));
    load_val = 4'd12;
    #1;
    chk("rej_j", 32'(j_out), 32'(0));
    chk("rej_k", 32'(k_out), 32'(0));
    tick();
    chk("rej_q", 32'(q), 32'(7));
    chk("rej_err", 32'(load_err), 32'(1));
    load = 1'b0; en = 1'b0;
    tick();
    chk("rej_err_clr", 32'(load_err), 32'(0));
    chk("hold_q", 32'(q), 32'(7));

    // 5. reset mid-count, with load also asserted
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1; reset = 1'b1;
    tick();
    chk("midrst_q", 32'(q), 32'(0));
    reset = 1'b0;
    tick();
    chk("resume1", 32'(q), 32'(1));
    tick();
    chk("resume2", 32'(q), 32'(2));
    load = 1'b1; load_val = 4'd3; reset = 1'b1;
    tick();
    chk("rst_ld_q", 32'(q), 32'(0));

    // 6. randomized run against the model
    mq = 0; merr = 0;
    for (int n = 0; n < 10000; n++) begin
      int d, etc;
      reset    = ($urandom_range(63, 0) == 0);
      load     = ($urandom_range(7, 0) == 0);
      load_val = 4'($urandom_range(15, 0));
      en       = ($urandom_range(3, 0) != 0);
      up_dn    = $urandom_range(1, 0) == 1;
      #1;
      d   = model_d(mq, load, int'(load_val), en, up_dn);
      etc = (en && !load) ? (up_dn ? int'(mq == MOD - 1) : int'(mq == 0)) : 0;
      chk("r_j", 32'(j_out), 32'(~mq & d & 15));
      chk("r_k", 32'(k_out), 32'(mq & ~d & 15));
      chk("r_jk_excl", 32'(j_out & k_out), 32'(0));
      chk("r_qbar", 32'(qbar), 32'(~mq & 15));
      chk("r_tc", 32'(tc), 32'(etc));
      chk("r_inrange", 32'(q < 4'(MOD)), 32'(1));
      tick();
      if (reset) begin
        mq = 0; merr = 0;
      end else begin
        merr = (load && int'(load_val) >= MOD) ? 1 : 0;
        mq   = d;
      end
      chk("r_q", 32'(q), 32'(mq));
      chk("r_err", 32'(load_err), 32'(merr));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
